multi_cam_imag_save: RTL
========================

Name: multi_cam_imag_save

Overview:
- Parametrised successor to the two-camera save path. Merges NUM_CAM camera pixel streams into one frame-buffer write port.
- Each channel has its own small FIFO; channels are served by a round-robin arbiter.
- Frame-buffer addresses are generated for a run-time selectable layout: single camera, side-by-side, stacked or blank.
- Sits between the camera capture blocks and the frame-buffer BRAM write port.

Parameters:
- CAM_DATA_WIDTH, 12, pixel data width
- CAM_LINE, 9, line index width
- CAM_PIXEL, 10, pixel index width
- NUM_CAM, 2, camera channels; power of two, 2..4
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, >=2
- ADDR_WIDTH, 17, frame-buffer address width
- FB_WIDTH, 320, frame-buffer pixels per line
- FB_DEPTH, 240, frame-buffer lines

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- i_mode  in  2  layout: 0 single, 1 side-by-side, 2 stacked, 3 blank
- i_sel  in  $clog2(NUM_CAM)  camera shown in mode 0
- i_we  in  NUM_CAM  per-channel pixel valid
- i_data  in  NUM_CAM*CAM_DATA_WIDTH  packed pixel data; channel c at slice c
- i_line  in  NUM_CAM*CAM_LINE  packed line index
- i_pixel  in  NUM_CAM*CAM_PIXEL  packed pixel index
- o_we  out  1  frame-buffer write enable
- o_addr_wr  out  ADDR_WIDTH  frame-buffer write address
- o_data_wr  out  CAM_DATA_WIDTH  frame-buffer write data
- o_overflow  out  NUM_CAM  sticky per-channel FIFO overflow flag
- o_frame_done  out  1  one-cycle pulse on the write to the last frame-buffer address

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - o_we=0, o_addr_wr=0, o_data_wr=0, o_overflow=0, o_frame_done=0.
  - FIFOs emptied, arbiter pointer=0, latched mode=3 (blank), latched sel=0.
  - Reset mid-frame discards all buffered pixels with no partial flush.
- Per-channel FIFO:
  - Pushes {data, line, pixel} when i_we[c]=1 and the FIFO is not full.
  - If i_we[c]=1 while full, the pixel is dropped and o_overflow[c] is set. It stays set until reset.
  - Push and pop in the same cycle on a full FIFO is allowed: the pop frees a slot, the push succeeds, and there is no overflow.
- Arbiter:
  - Each cycle it grants one non-empty channel, searching from the pointer upward with wrap.
  - After a grant the pointer becomes (granted+1) mod NUM_CAM. The pointer holds when there is no grant.
  - The granted FIFO pops in that cycle.
- Mode latch:
  - i_mode/i_sel are sampled when the popped entry is from channel 0 with line=0 and pixel=0, i.e. at frame start.
  - The new mode applies from that pixel onward. Mid-frame changes to i_mode/i_sel are ignored until the next such entry.
- Address stage:
  - One register stage after the pop. Latency is 2: a pixel pushed at edge N with an idle arbiter appears with o_we=1 after edge N+2.
  - Mode 0:
    - Only channel i_sel is written; other channels are popped and discarded.
    - Address = line*FB_WIDTH + pixel.
  - Mode 1:
    - Write only if pixel mod NUM_CAM = 0.
    - Column = c*(FB_WIDTH/NUM_CAM) + pixel/NUM_CAM; row = line.
  - Mode 2:
    - Write only if line mod NUM_CAM = 0.
    - Row = c*(FB_DEPTH/NUM_CAM) + line/NUM_CAM; column = pixel.
  - Mode 3: pop and discard everything; o_we=0.
  - Address for modes 1/2 = row*FB_WIDTH + column.
  - Arithmetic is unsigned at ADDR_WIDTH+1 bits, then truncated to ADDR_WIDTH.
- Range check:
  - A pixel with computed column >= FB_WIDTH or row >= FB_DEPTH, before layout scaling, is popped but not written (o_we=0).
  - Partial-tile overlap is therefore impossible.
- Output registers:
  - o_data_wr and o_addr_wr update only when o_we=1; otherwise they hold their last value.
- o_frame_done: asserted in the same cycle as o_we=1 when o_addr_wr = FB_WIDTH*FB_DEPTH-1.
- Throughput: one write per cycle total. Sustained aggregate input above 1 pixel/cycle overflows.

Test Plan:
- Reset, then mode 0, sel 0; cam0 frame-start pixel (0,0)=0x123, then pixel (5,2)=0xABC. Expect o_we one cycle with addr 0/data 0x123, then addr 645/data 0xABC, each two edges after its push.
- Mode 1, NUM_CAM=2; cam0 and cam1 both push (line 3, pixel 10) in the same cycle. Expect two writes in consecutive cycles: cam0 at addr 965, then cam1 at addr 1125 (round robin). Odd pixels produce no writes.
- cam0 pushes 6 pixels back-to-back while cam1 pushes continuously with FIFO_DEPTH=4. Expect cam0 pixels never dropped, o_overflow[1]=1 after cam1 backlog exceeds 4, o_overflow[0]=0.
- Mode 2: cam1 pixel (line 4, pixel 7). Expect addr (120+2)*320+7=39047. A line-5 pixel produces no write.
- Mode 0: cam0 pixel at line 250 or pixel 330. Expect no write. Pixel (319,239) writes addr 76799 with o_frame_done=1 for exactly one cycle.
- Assert rst_n=0 for one edge with 3 entries buffered. Expect o_we=0 afterwards, no stale writes, o_overflow cleared, and blank mode until the next frame-start pixel.

Source files
------------

// File: rtl/multi_cam_imag_save.sv
// Merges NUM_CAM camera pixel streams into one frame-buffer write port.
// Each channel has its own FIFO; a round-robin arbiter pops them and a layout stage maps pixels to addresses.
module multi_cam_imag_save #(
  parameter int CAM_DATA_WIDTH = 12,
  parameter int CAM_LINE       = 9,
  parameter int CAM_PIXEL      = 10,
  parameter int NUM_CAM        = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_WIDTH     = 17,
  parameter int FB_WIDTH       = 320,
  parameter int FB_DEPTH       = 240
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          i_mode,
  input  logic [$clog2(NUM_CAM)-1:0]          i_sel,
  input  logic [NUM_CAM-1:0]                  i_we,
  input  logic [NUM_CAM*CAM_DATA_WIDTH-1:0]   i_data,
  input  logic [NUM_CAM*CAM_LINE-1:0]         i_line,
  input  logic [NUM_CAM*CAM_PIXEL-1:0]        i_pixel,
  output logic                                o_we,
  output logic [ADDR_WIDTH-1:0]               o_addr_wr,
  output logic [CAM_DATA_WIDTH-1:0]           o_data_wr,
  output logic [NUM_CAM-1:0]                  o_overflow,
  output logic                                o_frame_done
);
  localparam int CW  = $clog2(NUM_CAM);
  localparam int FW  = $clog2(FIFO_DEPTH);
  localparam int EW  = CAM_DATA_WIDTH + CAM_LINE + CAM_PIXEL;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] FB_W   = AW1'(FB_WIDTH);
  localparam logic [AW1-1:0] FB_D   = AW1'(FB_DEPTH);
  localparam logic [AW1-1:0] TILE_W = AW1'(FB_WIDTH / NUM_CAM);
  localparam logic [AW1-1:0] TILE_H = AW1'(FB_DEPTH / NUM_CAM);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_WIDTH * FB_DEPTH - 1);

  // Handshake: i_we[c] is a valid-only strobe with no ready; a push that finds
  // its FIFO full (and not popping this cycle) is dropped and flagged in o_overflow[c].
  logic [EW-1:0]         mem [NUM_CAM][FIFO_DEPTH];
  logic [FW:0]           wr_ptr [NUM_CAM];
  logic [FW:0]           rd_ptr [NUM_CAM];
  logic [NUM_CAM-1:0]    empty, full, push, pop;
  logic [CW-1:0]         arb_ptr, gnt_idx, cand;
  logic                  gnt_valid;
  logic [EW-1:0]         head;
  logic [CAM_LINE-1:0]   head_line;
  logic [CAM_PIXEL-1:0]  head_pixel;

  logic [1:0]                mode_q;
  logic [CW-1:0]             sel_q;
  logic                      s1_valid;
  logic [CW-1:0]             s1_ch;
  logic [CAM_DATA_WIDTH-1:0] s1_data;
  logic [CAM_LINE-1:0]       s1_line;
  logic [CAM_PIXEL-1:0]      s1_pixel;

  logic [AW1-1:0] line_w, pix_w, row, col, addr_full;
  logic           wr_ok, in_range, we_next;

  always_comb begin
    for (int c = 0; c < NUM_CAM; c++) begin
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      full[c]  = (wr_ptr[c][FW] != rd_ptr[c][FW]) &&
                 (wr_ptr[c][FW-1:0] == rd_ptr[c][FW-1:0]);
    end
  end

  // First non-empty channel at or after the pointer, wrapping.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    pop       = '0;
    for (int k = 0; k < NUM_CAM; k++) begin
      cand = arb_ptr + CW'(k);
      if (!gnt_valid && !empty[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_valid) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < NUM_CAM; c++) begin
      push[c] = i_we[c] && (!full[c] || pop[c]);
    end
  end

  assign head       = mem[gnt_idx][rd_ptr[gnt_idx][FW-1:0]];
  assign head_line  = head[CAM_PIXEL +: CAM_LINE];
  assign head_pixel = head[CAM_PIXEL-1:0];

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CAM; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c][FW-1:0]] <= {i_data[c*CAM_DATA_WIDTH +: CAM_DATA_WIDTH],
                                      i_line[c*CAM_LINE +: CAM_LINE],
                                      i_pixel[c*CAM_PIXEL +: CAM_PIXEL]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CAM; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      o_overflow <= '0;
    end else begin
      for (int c = 0; c < NUM_CAM; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (i_we[c] && full[c] && !pop[c]) o_overflow[c] <= 1'b1;
      end
    end
  end

  // Pop stage; the layout is re-latched when channel 0 delivers pixel (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_data  <= '0;
      s1_line  <= '0;
      s1_pixel <= '0;
      arb_ptr  <= '0;
      mode_q   <= 2'd3;
      sel_q    <= '0;
    end else begin
      s1_valid <= gnt_valid;
      if (gnt_valid) begin
        s1_ch    <= gnt_idx;
        s1_data  <= head[EW-1 -: CAM_DATA_WIDTH];
        s1_line  <= head_line;
        s1_pixel <= head_pixel;
        arb_ptr  <= gnt_idx + 1'b1;
        if (gnt_idx == '0 && head_line == '0 && head_pixel == '0) begin
          mode_q <= i_mode;
          sel_q  <= i_sel;
        end
      end
    end
  end

  always_comb begin
    line_w   = AW1'(s1_line);
    pix_w    = AW1'(s1_pixel);
    row      = line_w;
    col      = pix_w;
    wr_ok    = 1'b0;
    in_range = (pix_w < FB_W) && (line_w < FB_D);
    case (mode_q)
      2'd0: wr_ok = (s1_ch == sel_q);
      2'd1: begin
        wr_ok = (s1_pixel[CW-1:0] == '0);
        col   = AW1'(s1_ch) * TILE_W + (pix_w >> CW);
      end
      2'd2: begin
        wr_ok = (s1_line[CW-1:0] == '0);
        row   = AW1'(s1_ch) * TILE_H + (line_w >> CW);
      end
      default: wr_ok = 1'b0;
    endcase
    addr_full = row * FB_W + col;
    we_next   = s1_valid && in_range && wr_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_we         <= 1'b0;
      o_addr_wr    <= '0;
      o_data_wr    <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_we         <= we_next;
      o_frame_done <= we_next && (addr_full[ADDR_WIDTH-1:0] == LAST_ADDR);
      if (we_next) begin
        o_addr_wr <= addr_full[ADDR_WIDTH-1:0];
        o_data_wr <= s1_data;
      end
    end
  end
endmodule
